pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ckpt_fifo.sv | 70 +++++++
 rtl/pc_gen.sv | 144 ++++++++++++++
 tb/tb_pc_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg: shared constants and types for the fetch PC generator.
//   DEFAULT_XLEN : default PC width
//   INSN_BYTES   : bytes per instruction slot
//   pc_src_e     : next-PC source selection
// -----------------------------------------------------------------------------
package pc_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned INSN_BYTES   = 4;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_TRAP,
        SRC_RESTORE,
        SRC_ALU,
        SRC_HOLD,
        SRC_PRED,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ckpt_fifo.sv
// -----------------------------------------------------------------------------
// pc_ckpt_fifo: circular FIFO of fall-through addresses for predicted
// control transfers. Head entry is presented combinationally.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_data   enqueue i_data at tail
//   i_pop            dequeue head
//   i_flush          empty the FIFO (wins over push/pop)
//   o_head           head entry
//   o_count          occupied entries
//   o_full, o_empty  status flags
// -----------------------------------------------------------------------------
module pc_ckpt_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [XLEN-1:0]            i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [XLEN-1:0]            o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // Entry storage; no reset needed since count gates validity
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen: fetch program-counter generator with a checkpoint FIFO of
// fall-through addresses for early-predicted jumps/branches.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold PC
//   trap_valid/trap_target   CSR/trap redirect
//   alu_redirect/alu_target  EX redirect for non-predicted taken transfer
//   pred_taken/pred_offset   decode early prediction
//   ckpt_commit              oldest prediction correct, pop
//   ckpt_mispredict          oldest prediction wrong, restore from head
//   pc                       fetch PC
//   ckpt_count/ckpt_full     FIFO occupancy
//   pred_dropped             pulse: prediction suppressed (FIFO full)
//   ckpt_underflow           pulse: commit/mispredict with FIFO empty
//   misalign_err             misaligned PC flag (PC_GEN_MISALIGN_CHECK_EN)
// Optional feature macro: PC_GEN_MISALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     CKPT_DEPTH   = 4,
    parameter int unsigned     PRED_LAG     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          trap_valid,
    input  logic [XLEN-1:0]               trap_target,
    input  logic                          alu_redirect,
    input  logic [XLEN-1:0]               alu_target,
    input  logic                          pred_taken,
    input  logic [XLEN-1:0]               pred_offset,
    input  logic                          ckpt_commit,
    input  logic                          ckpt_mispredict,
    output logic [XLEN-1:0]               pc,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
    output logic                          ckpt_full,
    output logic                          pred_dropped,
    output logic                          ckpt_underflow,
    output logic                          misalign_err
);

    localparam logic [XLEN-1:0] STEP      = XLEN'(INSN_BYTES);
    localparam logic [XLEN-1:0] LAG_BYTES = XLEN'(INSN_BYTES * PRED_LAG);

    logic [XLEN-1:0] r_pc;
    logic            r_pred_dropped;
    logic            r_underflow;

    logic [XLEN-1:0] w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_restore;
    logic            w_flush;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_underflow;
    logic [XLEN-1:0] w_base;
    pc_src_e         w_src;

    // Address of the instruction currently in decode
    assign w_base = r_pc - LAG_BYTES;

    assign w_restore   = ckpt_mispredict & ~w_empty;
    assign w_flush     = trap_valid | w_restore | alu_redirect;
    assign w_push      = (w_src == SRC_PRED);
    assign w_pop       = ckpt_commit & ~w_empty & ~w_flush;
    assign w_drop      = pred_taken & w_full & ~stall & ~w_flush;
    assign w_underflow = (ckpt_commit | ckpt_mispredict) & w_empty;

    // Next-PC source priority
    always_comb begin
        w_src = SRC_SEQ;
        if (rst)                       w_src = SRC_RESET;
        else if (trap_valid)           w_src = SRC_TRAP;
        else if (w_restore)            w_src = SRC_RESTORE;
        else if (alu_redirect)         w_src = SRC_ALU;
        else if (stall)                w_src = SRC_HOLD;
        else if (pred_taken && !w_full) w_src = SRC_PRED;
        else                           w_src = SRC_SEQ;
    end

    always_ff @(posedge clk) begin
        case (w_src)
            SRC_RESET:   r_pc <= RESET_VECTOR;
            SRC_TRAP:    r_pc <= trap_target;
            SRC_RESTORE: r_pc <= w_head;
            SRC_ALU:     r_pc <= alu_target;
            SRC_HOLD:    r_pc <= r_pc;
            SRC_PRED:    r_pc <= w_base + pred_offset;
            default:     r_pc <= r_pc + STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_dropped <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_pred_dropped <= w_drop;
            r_underflow    <= w_underflow;
        end
    end

    pc_ckpt_fifo #(
        .XLEN  (XLEN),
        .DEPTH (CKPT_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_base + STEP),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (ckpt_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic r_misalign;

    // Flags the cycle after a misaligned value lands in pc
    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= |r_pc[1:0];
    end

    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

    assign pc             = r_pc;
    assign ckpt_full      = w_full;
    assign pred_dropped   = r_pred_dropped;
    assign ckpt_underflow = r_underflow;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen: scoreboard bench for pc_gen. Stimulus drives at negedge and
// pushes the reference model's expected outputs; a monitor pops and compares
// one entry per clock, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAG   = 1;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, trap_valid, alu_redirect, pred_taken;
    logic        ckpt_commit, ckpt_mispredict;
    logic [31:0] trap_target, alu_target, pred_offset;
    logic [31:0] pc;
    logic [2:0]  ckpt_count;
    logic        ckpt_full, pred_dropped, ckpt_underflow, misalign_err;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .CKPT_DEPTH   (DEPTH),
        .PRED_LAG     (LAG)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .alu_redirect    (alu_redirect),
        .alu_target      (alu_target),
        .pred_taken      (pred_taken),
        .pred_offset     (pred_offset),
        .ckpt_commit     (ckpt_commit),
        .ckpt_mispredict (ckpt_mispredict),
        .pc              (pc),
        .ckpt_count      (ckpt_count),
        .ckpt_full       (ckpt_full),
        .pred_dropped    (pred_dropped),
        .ckpt_underflow  (ckpt_underflow),
        .misalign_err    (misalign_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] count;
        logic        full;
        logic        drop;
        logic        uf;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs and record what the outputs must be after the edge
    task automatic step(input logic r, input logic st, input logic tv, input logic [31:0] tt,
                        input logic ar, input logic [31:0] at, input logic pt,
                        input logic [31:0] po, input logic cc, input logic cm);
        exp_t        e;
        logic        empty;
        logic        full;
        logic [31:0] base;
        @(negedge clk);
        rst = r; stall = st; trap_valid = tv; trap_target = tt;
        alu_redirect = ar; alu_target = at; pred_taken = pt; pred_offset = po;
        ckpt_commit = cc; ckpt_mispredict = cm;
        e.drop = 1'b0;
        e.uf   = 1'b0;
        e.mis  = 1'b0;
        if (r) begin
            m_pc = RV;
            m_q.delete();
        end else begin
            empty = (m_q.size() == 0);
            full  = (m_q.size() == DEPTH);
            base  = m_pc - 32'(4 * LAG);
`ifdef PC_GEN_MISALIGN_CHECK_EN
            e.mis = (m_pc[1:0] != 2'b00);
`endif
            e.uf = (cc || cm) && empty;
            if (tv) begin
                m_pc = tt;
                m_q.delete();
            end else if (cm && !empty) begin
                m_pc = m_q[0];
                m_q.delete();
            end else if (ar) begin
                m_pc = at;
                m_q.delete();
            end else begin
                if (cc && !empty) void'(m_q.pop_front());
                if (st) begin
                end else if (pt && !full) begin
                    m_q.push_back(base + 32'd4);
                    m_pc = base + po;
                end else begin
                    e.drop = pt;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end
        e.pc    = m_pc;
        e.count = 32'(m_q.size());
        e.full  = (m_q.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed check of outputs right after the edge that follows the last step
    task automatic post_pc(input string name, input logic [31:0] want);
        @(posedge clk);
        #1;
        chk(name, pc, want);
    endtask

    // Monitor: one expected entry per clock while the scoreboard has work
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_count", 32'(ckpt_count), e.count);
                chk("sb_full", 32'(ckpt_full), 32'(e.full));
                chk("sb_dropped", 32'(pred_dropped), 32'(e.drop));
                chk("sb_underflow", 32'(ckpt_underflow), 32'(e.uf));
                chk("sb_misalign", 32'(misalign_err), 32'(e.mis));
            end
        end
    end

    initial begin
        logic [31:0] tt, at, po;
        int          drain;
        rst = 1'b1; stall = 1'b0; trap_valid = 1'b0; trap_target = '0;
        alu_redirect = 1'b0; alu_target = '0; pred_taken = 1'b0; pred_offset = '0;
        ckpt_commit = 1'b0; ckpt_mispredict = 1'b0;
        m_pc = RV;

        // Reset and free-running increment
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        post_pc("reset_pc", 32'h0);
        chk("reset_count", 32'(ckpt_count), 32'd0);
        idle(); post_pc("seq_4", 32'h4);
        idle(); post_pc("seq_8", 32'h8);
        idle(); post_pc("seq_c", 32'hC);
        idle(); post_pc("seq_10", 32'h10);

        // Prediction then mispredict restore from checkpoint
        step(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        post_pc("pred_target", 32'h4C);
        chk("pred_count", 32'(ckpt_count), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        post_pc("restore_pc", 32'h10);
        chk("restore_count", 32'(ckpt_count), 32'd0);

        // Fill the FIFO and overflow with a fifth prediction
        step(0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        post_pc("fill_pc", 32'h200);
        chk("fill_full", 32'(ckpt_full), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        post_pc("drop_pc", 32'h204);
        chk("drop_pulse", 32'(pred_dropped), 32'd1);
        chk("drop_count", 32'(ckpt_count), 32'd4);

        // Every redirect source at once: trap wins
        step(0, 1, 1, 32'h8000_0000, 1, 32'h1234, 1, 32'h8, 0, 1);
        post_pc("trap_prio_pc", 32'h8000_0000);
        chk("trap_prio_count", 32'(ckpt_count), 32'd0);

        // Push and commit together, then restore shows the advanced head
        step(0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h8, 1, 0);
        post_pc("pushpop_pc", 32'h8000_000C);
        chk("pushpop_count", 32'(ckpt_count), 32'd2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        post_pc("head_adv_pc", 32'h8000_0004);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        post_pc("underflow_pc", 32'h8000_0008);
        chk("underflow_pulse", 32'(ckpt_underflow), 32'd1);

        // Misaligned redirect
        step(0, 0, 0, 0, 1, 32'h102, 0, 0, 0, 0);
        post_pc("misalign_pc", 32'h102);
        idle();
        post_pc("misalign_seq", 32'h106);
`ifdef PC_GEN_MISALIGN_CHECK_EN
        chk("misalign_flag", 32'(misalign_err), 32'd1);
`else
        chk("misalign_flag", 32'(misalign_err), 32'd0);
`endif

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            tt = $urandom();
            at = $urandom();
            po = $urandom_range(0, 255) << 2;
            if ($urandom_range(0, 9) == 0) tt[1:0] = 2'($urandom());
            else                           tt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) at[1:0] = 2'($urandom());
            else                           at[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) po = $urandom();
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0), tt,
                 ($urandom_range(0, 19) == 0), at,
                 ($urandom_range(0, 2) == 0), po,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 14) == 0));
        end

        // Let the monitor consume the remaining expectations
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending want 0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
